// File: rtl/seg7_dec_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Optional feature macro: SEG7_DEC_HEX_EN (adds A,b,C,d,E,F glyphs).
package seg7_dec_pkg;

  // Segment line order on seg_in: bit0 = a ... bit6 = g.
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_t;

  localparam int unsigned SEG_WIDTH = 7;

  // Glyph table indexed by the value it represents (0..9, then A..F).
  localparam logic [SEG_WIDTH-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [SEG_WIDTH-1:0] GLYPH_BLANK = 7'h00;

`ifdef SEG7_DEC_HEX_EN
  localparam int unsigned NUM_GLYPHS = 16;
`else
  localparam int unsigned NUM_GLYPHS = 10;
`endif

  // Stability tracker states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational segment-pattern to digit-value lookup.
// Hex letters are recognised only when SEG7_DEC_HEX_EN is defined.
module seg7_glyph_decode
  import seg7_dec_pkg::*;
(
  input  logic [SEG_WIDTH-1:0] pattern,
  output logic [3:0]           value,
  output logic                 legal,
  output logic                 blank
);

  // Search the glyph table; blank is reported separately and is never legal.
  always_comb begin
    value = '0;
    legal = 1'b0;
    blank = (pattern == GLYPH_BLANK);
    for (int unsigned k = 0; k < NUM_GLYPHS; k++) begin
      if (pattern == GLYPH[k]) begin
        value = 4'(k);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed seven-segment display bus back into digit values.
// Each strobed digit must be stable for STABLE_CYCLES samples before capture.
// Optional feature macro: SEG7_DEC_HEX_EN (hex letters decode as 10..15).
module seg7_scan_decoder
  import seg7_dec_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_WIDTH-1:0]    seg_in,
  input  logic                    dp_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic                    frame_done,
  output logic                    err
);

  localparam logic [7:0]            STABLE_CNT = 8'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

  logic [SEG_WIDTH-1:0]  sample_seg, prev_seg;
  logic                  sample_dp,  prev_dp;
  logic [NUM_DIGITS-1:0] sample_sel, prev_sel;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       capture;
  logic       one_hot, same;

  logic [3:0] dec_value;
  logic       dec_legal, dec_blank;

  logic [NUM_DIGITS-1:0] mask_q, mask_set;

  // Input stage plus a one-sample history used for the stability comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_seg <= '0;
      sample_dp  <= 1'b0;
      sample_sel <= '0;
      prev_seg   <= '0;
      prev_dp    <= 1'b0;
      prev_sel   <= '0;
    end else begin
      sample_seg <= seg_in;
      sample_dp  <= dp_in;
      sample_sel <= dig_sel;
      prev_seg   <= sample_seg;
      prev_dp    <= sample_dp;
      prev_sel   <= sample_sel;
    end
  end

  assign one_hot = (sample_sel != '0) && ((sample_sel & (sample_sel - SEL_ONE)) == '0);
  assign same    = (sample_seg == prev_seg) && (sample_dp == prev_dp) && (sample_sel == prev_sel);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Stability FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; capture fires on the edge where the count reaches the threshold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (one_hot) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!one_hot) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE_CNT) begin
            capture = 1'b1;
            state_d = ST_HELD;
          end
        end else begin
          cnt_d = 8'd1;
        end
      end
      ST_HELD: begin
        if (!same) begin
          if (one_hot) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  seg7_glyph_decode u_decode (
    .pattern (sample_seg),
    .value   (dec_value),
    .legal   (dec_legal),
    .blank   (dec_blank)
  );

  assign mask_set = mask_q | sample_sel;

  // Capture into the strobed digit slot and track which digits the frame has seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits     <= '0;
      dp_out     <= '0;
      valid      <= '0;
      mask_q     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (capture) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (sample_sel[i]) begin
            dp_out[i] <= sample_dp;
            if (dec_legal) begin
              digits[4*i +: 4] <= dec_value;
              valid[i]         <= 1'b1;
            end else if (dec_blank) begin
              digits[4*i +: 4] <= '0;
              valid[i]         <= 1'b0;
            end else begin
              valid[i]         <= 1'b0;
            end
          end
        end
        err <= !dec_legal && !dec_blank;
        // The mask clears on the same edge that reports the completed frame.
        if (&mask_set) begin
          frame_done <= 1'b1;
          mask_q     <= '0;
        end else begin
          mask_q     <= mask_set;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus a
// randomized run checked against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int unsigned N = 4;
  localparam int unsigned S = 4;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
`ifdef SEG7_DEC_HEX_EN
  localparam int NLEGAL = 16;
`else
  localparam int NLEGAL = 10;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [6:0]     seg_in = '0;
  logic           dp_in = 1'b0;
  logic [N-1:0]   dig_sel = '0;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_out;
  logic [N-1:0]   valid;
  logic           frame_done;
  logic           err;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [6:0]     m_pend_seg, m_last_seg;
  logic           m_pend_dp,  m_last_dp;
  logic [N-1:0]   m_pend_sel, m_last_sel;
  int             m_run;
  logic [N-1:0]   m_mask;
  logic [4*N-1:0] exp_digits;
  logic [N-1:0]   exp_dp, exp_valid;
  logic           exp_err, exp_frame;

  seg7_scan_decoder #(
    .NUM_DIGITS    (N),
    .STABLE_CYCLES (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .dig_sel    (dig_sel),
    .digits     (digits),
    .dp_out     (dp_out),
    .valid      (valid),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend_seg = '0; m_pend_dp = 1'b0; m_pend_sel = '0;
    m_last_seg = '0; m_last_dp = 1'b0; m_last_sel = '0;
    m_run = 0; m_mask = '0;
    exp_digits = '0; exp_dp = '0; exp_valid = '0;
    exp_err = 1'b0; exp_frame = 1'b0;
  endtask

  // Model: a digit is captured when its run of identical one-hot samples reaches S.
  task automatic model_edge();
    int val;
    int idx;
    exp_err   = 1'b0;
    exp_frame = 1'b0;
    if ($countones(m_pend_sel) == 1) begin
      if (m_run > 0 && m_pend_seg == m_last_seg && m_pend_dp == m_last_dp && m_pend_sel == m_last_sel)
        m_run = m_run + 1;
      else
        m_run = 1;
    end else begin
      m_run = 0;
    end
    if (m_run == S) begin
      idx = 0;
      for (int k = 0; k < N; k++) if (m_pend_sel[k]) idx = k;
      val = -1;
      for (int k = 0; k < NLEGAL; k++) if (GLYPHS[k] == m_pend_seg) val = k;
      exp_dp[idx] = m_pend_dp;
      if (val >= 0) begin
        exp_digits[4*idx +: 4] = 4'(val);
        exp_valid[idx] = 1'b1;
      end else if (m_pend_seg == 7'h00) begin
        exp_digits[4*idx +: 4] = 4'h0;
        exp_valid[idx] = 1'b0;
      end else begin
        exp_valid[idx] = 1'b0;
        exp_err = 1'b1;
      end
      m_mask = m_mask | m_pend_sel;
      if (m_mask == {N{1'b1}}) begin
        exp_frame = 1'b1;
        m_mask = '0;
      end
    end
    m_last_seg = m_pend_seg; m_last_dp = m_pend_dp; m_last_sel = m_pend_sel;
    m_pend_seg = seg_in;     m_pend_dp = dp_in;     m_pend_sel = dig_sel;
  endtask

  task automatic step(input logic [6:0] s, input logic d, input logic [N-1:0] sel);
    seg_in = s; dp_in = d; dig_sel = sel;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (digits !== '0)     begin fails++; $display("FAIL reset_digits: got %h expected 0", digits); end
    checks++; if (valid !== '0)      begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (dp_out !== '0)     begin fails++; $display("FAIL reset_dp: got %b expected 0", dp_out); end
    checks++; if (err !== 1'b0)      begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame: got %b expected 0", frame_done); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stable_capture();
    do_reset();
    repeat (S) step(7'h4F, 1'b0, 4'b0001);
    checks++; if (valid !== 4'b0000) begin fails++; $display("FAIL early_capture: valid got %b expected 0000", valid); end
    step(7'h4F, 1'b0, 4'b0001);
    checks++; if (digits[3:0] !== 4'd3) begin fails++; $display("FAIL stable_digit: got %h expected 3", digits[3:0]); end
    checks++; if (valid !== 4'b0001) begin fails++; $display("FAIL stable_valid: got %b expected 0001", valid); end
  endtask

  task automatic test_scan();
    int pulses = 0;
    int errs = 0;
    do_reset();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 6; c++) begin
        step(GLYPHS[d+1], 1'b0, N'(1) << d);
        pulses += int'(frame_done);
        errs += int'(err);
      end
    end
    repeat (3) begin
      step(7'h00, 1'b0, 4'b0000);
      pulses += int'(frame_done);
    end
    checks++; if (digits !== 16'h4321) begin fails++; $display("FAIL scan_digits: got %h expected 4321", digits); end
    checks++; if (valid !== 4'hF) begin fails++; $display("FAIL scan_valid: got %b expected 1111", valid); end
    checks++; if (pulses != 1) begin fails++; $display("FAIL scan_frame_pulses: got %0d expected 1", pulses); end
    checks++; if (errs != 0) begin fails++; $display("FAIL scan_err: got %0d expected 0", errs); end
  endtask

  task automatic test_glitch();
    int errs = 0;
    int changes = 0;
    for (int r = 0; r < 10; r++) begin
      repeat (2) begin step(7'h3F, 1'b0, 4'b0010); errs += int'(err); changes += int'(valid !== 4'hF); end
      repeat (2) begin step(7'h06, 1'b0, 4'b0010); errs += int'(err); changes += int'(valid !== 4'hF); end
    end
    checks++; if (changes != 0) begin fails++; $display("FAIL glitch_valid: got %0d changed cycles expected 0", changes); end
    checks++; if (digits !== 16'h4321) begin fails++; $display("FAIL glitch_digits: got %h expected 4321", digits); end
    checks++; if (errs != 0) begin fails++; $display("FAIL glitch_err: got %0d expected 0", errs); end
  endtask

  task automatic test_hex();
    int errs = 0;
    do_reset();
    repeat (6) begin step(7'h77, 1'b1, 4'b0001); errs += int'(err); end
    checks++; if (dp_out[0] !== 1'b1) begin fails++; $display("FAIL hex_dp: got %b expected 1", dp_out[0]); end
`ifdef SEG7_DEC_HEX_EN
    checks++; if (digits[3:0] !== 4'hA) begin fails++; $display("FAIL hex_digit: got %h expected a", digits[3:0]); end
    checks++; if (valid[0] !== 1'b1) begin fails++; $display("FAIL hex_valid: got %b expected 1", valid[0]); end
    checks++; if (errs != 0) begin fails++; $display("FAIL hex_err: got %0d expected 0", errs); end
`else
    checks++; if (digits[3:0] !== 4'h0) begin fails++; $display("FAIL hex_digit: got %h expected 0", digits[3:0]); end
    checks++; if (valid[0] !== 1'b0) begin fails++; $display("FAIL hex_valid: got %b expected 0", valid[0]); end
    checks++; if (errs != 1) begin fails++; $display("FAIL hex_err: got %0d pulses expected 1", errs); end
`endif
  endtask

  task automatic test_multi_hot();
    int errs = 0;
    do_reset();
    repeat (10) begin step(7'h06, 1'b0, 4'b0011); errs += int'(err); end
    checks++; if (valid !== 4'b0000 || digits !== '0) begin fails++; $display("FAIL multi_nocapture: valid %b digits %h expected 0", valid, digits); end
    checks++; if (errs != 0) begin fails++; $display("FAIL multi_err: got %0d expected 0", errs); end
    repeat (S) step(7'h06, 1'b0, 4'b0001);
    checks++; if (valid !== 4'b0000) begin fails++; $display("FAIL multi_early: valid got %b expected 0000", valid); end
    step(7'h06, 1'b0, 4'b0001);
    checks++; if (valid !== 4'b0001 || digits[3:0] !== 4'd1) begin fails++; $display("FAIL multi_capture: valid %b digit %h expected 0001/1", valid, digits[3:0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (6) step(7'h6D, 1'b1, 4'b0001);
    checks++; if (valid !== 4'b0001 || digits[3:0] !== 4'd5) begin fails++; $display("FAIL mid_pre: valid %b digit %h expected 0001/5", valid, digits[3:0]); end
    repeat (4) step(7'h07, 1'b1, 4'b0100);
    rst = 1'b1;
    #1;
    checks++; if (digits !== '0 || valid !== '0 || dp_out !== '0 || err !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL mid_async_clear: digits %h valid %b dp %b err %b frame %b expected all 0", digits, valid, dp_out, err, frame_done);
    end
    rst = 1'b0;
    model_reset();
    repeat (S) step(7'h07, 1'b1, 4'b0100);
    checks++; if (valid !== 4'b0000) begin fails++; $display("FAIL mid_early: valid got %b expected 0000", valid); end
    step(7'h07, 1'b1, 4'b0100);
    checks++; if (valid !== 4'b0100 || digits[11:8] !== 4'd7 || dp_out !== 4'b0100) begin
      fails++; $display("FAIL mid_capture: valid %b digit %h dp %b expected 0100/7/0100", valid, digits[11:8], dp_out);
    end
  endtask

  task automatic test_random();
    logic [6:0]   s;
    logic         d;
    logic [N-1:0] sel;
    int           len;
    int           cyc = 0;
    do_reset();
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(0, 3))
        0, 1:    s = GLYPHS[$urandom_range(0, 15)];
        2:       s = 7'h00;
        default: s = 7'($urandom);
      endcase
      d = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       sel = '0;
        1:       sel = N'($urandom);
        default: sel = N'(1) << $urandom_range(0, N-1);
      endcase
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        step(s, d, sel);
        cyc++;
        checks++; if (digits !== exp_digits) begin fails++; $display("FAIL rand_digits cyc %0d: got %h expected %h", cyc, digits, exp_digits); end
        checks++; if (valid !== exp_valid) begin fails++; $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, valid, exp_valid); end
        checks++; if (dp_out !== exp_dp) begin fails++; $display("FAIL rand_dp cyc %0d: got %b expected %b", cyc, dp_out, exp_dp); end
        checks++; if (err !== exp_err) begin fails++; $display("FAIL rand_err cyc %0d: got %b expected %b", cyc, err, exp_err); end
        checks++; if (frame_done !== exp_frame) begin fails++; $display("FAIL rand_frame cyc %0d: got %b expected %b", cyc, frame_done, exp_frame); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stable_capture();
    test_scan();
    test_glitch();
    test_hex();
    test_multi_hot();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before capture, range 2..255.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port seg_in, input, 7: segment lines, active-high, bit0=a .. bit6=g.
REQ-006 SHALL have port dp_in, input, 1: decimal-point line, active-high.
REQ-007 SHALL have port dig_sel, input, NUM_DIGITS: digit strobe, one-hot active-high, bit i = digit i.
REQ-008 SHALL have port digits, output, 4*NUM_DIGITS: decoded value of digit i at [4i+3:4i].
REQ-009 SHALL have port dp_out, output, NUM_DIGITS: captured decimal point per digit.
REQ-010 SHALL have port valid, output, NUM_DIGITS: digit i holds a legal glyph.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse when every digit has been captured since the previous pulse.
REQ-012 SHALL have port err, output, 1: one-cycle pulse when an illegal glyph is captured.

Function
REQ-013 SHALL register seg_in, dp_in and dig_sel in one input stage; all further logic uses the registered copy ("sample").
REQ-014 SHALL run FSM IDLE / SETTLE / HELD on a stability counter cnt (8 bits, saturating).
REQ-015 SHALL enter and stay in IDLE, cnt=0, while the sample dig_sel is zero or has more than one bit set.
REQ-016 SHALL go IDLE->SETTLE with cnt=1 on the first one-hot sample; in SETTLE, identical sample (seg, dp, dig_sel) increments cnt; differing one-hot sample restarts cnt=1.
REQ-017 SHALL capture on the edge at which cnt reaches STABLE_CYCLES, then go to HELD; capture visible on outputs at that edge (STABLE_CYCLES+1 edges after pin change).
REQ-018 SHALL perform no further capture in HELD until the sample changes; a change returns to SETTLE (one-hot) or IDLE (not one-hot).
REQ-019 SHALL on capture of digit i: legal glyph -> digits[i]=value, valid[i]=1; blank (0x00) -> digits[i]=0, valid[i]=0, no err; other -> digits[i] unchanged, valid[i]=0, err pulse; dp_out[i]=dp sample always.
REQ-020 SHALL use glyphs 0..9 = 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F.
REQ-021 SHALL set a capture-mask bit i on every capture (legal, blank or illegal); when the mask becomes all-ones, frame_done pulses for one cycle and the mask clears on that same edge.
REQ-022 SHALL hold digits/valid/dp_out of uncaptured digits unchanged indefinitely.

Reset
REQ-023 SHALL asynchronously on rst=1 clear input stage, cnt, mask, digits, dp_out, valid, frame_done, err to 0 and force IDLE, including mid-SETTLE.
REQ-024 SHALL after rst deasserts require a full STABLE_CYCLES dwell before any capture.

Configuration
REQ-025 SHALL, with SEG7_DEC_HEX_EN defined, also decode A,b,C,d,E,F = 0x77,0x7C,0x39,0x5E,0x79,0x71 as values 10..15, valid=1.
REQ-026 SHALL, without SEG7_DEC_HEX_EN, treat those six patterns as illegal (valid=0, err pulse).

Structure
REQ-027 SHALL place glyph constants, the FSM state enum and the segment bit-order constants in package seg7_dec_pkg.
REQ-028 SHALL implement pattern-to-value lookup in combinational sub-module seg7_glyph_decode (in: 7-bit pattern; out: value, legal, blank).

Verification
REQ-029 SHALL test: NUM_DIGITS=4, STABLE_CYCLES=4, dig_sel=0001, seg_in=0x4F held 4 samples -> digits[3:0]=3, valid=0001 on 4th sample edge; none after 3.
REQ-030 SHALL test: scan 0x06,0x5B,0x4F,0x66 on digits 0..3, 6 cycles each -> digits=0x4321, valid=1111, frame_done exactly one pulse after digit 3 capture.
REQ-031 SHALL test: seg_in toggles 0x3F/0x06 every 2 cycles with dig_sel=0010 -> no capture, valid unchanged, no err.
REQ-032 SHALL test: seg_in=0x77 on digit 0 -> with SEG7_DEC_HEX_EN digits[3:0]=0xA, valid[0]=1; without it valid[0]=0 and one err pulse.
REQ-033 SHALL test: dig_sel=0011 for 10 cycles -> FSM IDLE, no capture; then 0001 -> capture after 4 samples.
REQ-034 SHALL test: rst pulse at cnt=3 -> all outputs 0 immediately; capture only after 4 further identical samples.
